// File: rtl/i2c_write_engine_if.sv
// Handshake between the codec register sequencer (master) and the I2C write engine (slave).
interface i2c_write_engine_if #(
    parameter int unsigned NBYTES = 3
);
    logic [8*NBYTES-1:0] i2c_data;
    logic                go;
    logic                done;
    logic                busy;
    logic [NBYTES-1:0]   ack;

    modport master (output i2c_data, go, input done, busy, ack);
    modport slave (input i2c_data, go, output done, busy, ack);
endinterface

// File: rtl/i2c_write_engine.sv
// Bit-level I2C master write engine: START, NBYTES x (8 bits + ACK slot), STOP, four clocks per bit.
// Optional build macro I2C_NACK_ABORT_EN: a NACK ends the transfer with STOP after that ACK slot.
module i2c_write_engine #(
    parameter int unsigned NBYTES = 3
) (
    input  logic                clk_i2c,
    input  logic                reset,
    i2c_write_engine_if.slave   req,
    output logic                I2C_SCLK,
    inout  wire                 I2C_SDAT
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StBit, StStop, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        q_q, q_d;
    logic [3:0]        bit_q, bit_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [W-1:0]      data_q, data_d;
    logic [NBYTES-1:0] ack_q, ack_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              sclk_q, sclk_d;
    logic              oe_q, oe_d;

    logic          sda_in;
    logic          is_ack;
    logic          last_byte;
    logic [BW-1:0] idx;
    logic          nack_stop;

    assign sda_in    = I2C_SDAT;
    assign is_ack    = (bit_q == 4'd8);
    assign last_byte = (byte_q == BW'(NBYTES - 1));
    // ack[] is ordered with the first byte in the MSB
    assign idx       = BW'(NBYTES - 1) - byte_q;

`ifdef I2C_NACK_ABORT_EN
    assign nack_stop = ack_q[idx];
`else
    assign nack_stop = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        data_d  = data_q;
        ack_d   = ack_q;
        done_d  = done_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                q_d = 2'd0;
                if (req.go && !done_q) begin
                    state_d = StStart;
                    data_d  = req.i2c_data;
                    ack_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                q_d = q_q + 2'd1;
                if (q_q == 2'd3) begin
                    state_d = StBit;
                    bit_d   = 4'd0;
                    byte_d  = '0;
                end
            end
            StBit: begin
                q_d = q_q + 2'd1;
                if (is_ack && q_q == 2'd2 && sda_in) begin
                    ack_d[idx] = 1'b1;
                end
                if (q_q == 2'd3) begin
                    if (!is_ack) begin
                        data_d = data_q << 1;
                        bit_d  = bit_q + 4'd1;
                    end else if (last_byte || nack_stop) begin
                        state_d = StStop;
                        // Bytes that will never be sent report as NACK
                        for (int unsigned i = 0; i < NBYTES; i++) begin
                            if (nack_stop && i < 32'(idx)) begin
                                ack_d[i] = 1'b1;
                            end
                        end
                    end else begin
                        bit_d  = 4'd0;
                        byte_d = byte_q + BW'(1);
                    end
                end
            end
            StStop: begin
                q_d = q_q + 2'd1;
                if (q_q == 2'd3) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            StDone: begin
                if (!req.go) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus pins are decoded from the phase being entered so they are registered with it
    always_comb begin
        sclk_d = 1'b1;
        oe_d   = 1'b0;
        unique case (state_d)
            StStart: begin
                sclk_d = (q_d < 2'd2);
                oe_d   = 1'b1;
            end
            StBit: begin
                sclk_d = (q_d == 2'd1) || (q_d == 2'd2);
                oe_d   = (bit_d != 4'd8) && !data_d[W-1];
            end
            StStop: begin
                sclk_d = (q_d != 2'd0);
                oe_d   = (q_d < 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            state_q <= StIdle;
            q_q     <= 2'd0;
            bit_q   <= 4'd0;
            byte_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            oe_q    <= oe_d;
        end
    end

    assign I2C_SCLK = sclk_q;
    assign I2C_SDAT = oe_q ? 1'b0 : 1'bz;
    assign req.done = done_q;
    assign req.busy = busy_q;
    assign req.ack  = ack_q;
endmodule

// File: tb/tb_i2c_write_engine.sv
// Scoreboard bench for i2c_write_engine: expected bytes and completions queued by stimulus,
// checked by a bus decoder and a completion monitor.
module tb_i2c_write_engine;
`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl;
    wire  sda;
    logic slave_drive = 1'b0;
    logic [2:0] nack_mask = 3'b000;
    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int starts = 0;

    assign sda = slave_drive ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_write_engine_if #(.NBYTES(3)) bus_if ();

    i2c_write_engine #(.NBYTES(3)) dut (
        .clk_i2c (clk),
        .reset   (reset),
        .req     (bus_if.slave),
        .I2C_SCLK(scl),
        .I2C_SDAT(sda)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] ack;
        int         start;
        int         lat;
    } done_exp_t;

    logic [7:0] exp_byte_q[$];
    int         exp_nb_q[$];
    done_exp_t  exp_done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Bus decoder and slave acknowledge model
    initial begin
        logic pscl, psda, cscl, csda, in_xfer;
        logic [7:0] sh;
        int bitcnt, bytecnt;
        pscl = 1'b1; psda = 1'b1; in_xfer = 1'b0; sh = '0; bitcnt = 0; bytecnt = 0;
        forever begin
            @(negedge clk);
            cscl = scl;
            csda = sda;
            if (pscl && cscl && psda && !csda) begin
                starts++;
                in_xfer = 1'b1;
                bitcnt  = 0;
                bytecnt = 0;
            end else if (pscl && cscl && !psda && csda) begin
                if (in_xfer) begin
                    if (exp_nb_q.size() == 0) fail_now("unexpected_stop");
                    else check("stop_byte_count", bytecnt, exp_nb_q.pop_front());
                end
                in_xfer = 1'b0;
            end else if (!pscl && cscl && in_xfer) begin
                if (bitcnt < 8) sh = {sh[6:0], csda};
                bitcnt++;
                if (bitcnt == 9) begin
                    if (exp_byte_q.size() == 0) fail_now("unexpected_byte");
                    else check("bus_byte", sh, exp_byte_q.pop_front());
                    bytecnt++;
                end
            end else if (pscl && !cscl && in_xfer) begin
                if (bitcnt == 8 && bytecnt < 3) slave_drive = !nack_mask[2-bytecnt];
                else if (bitcnt == 9) begin
                    slave_drive = 1'b0;
                    bitcnt = 0;
                end
            end
            pscl = cscl;
            psda = csda;
        end
    end

    // Completion monitor
    initial begin
        logic pdone;
        done_exp_t e;
        pdone = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.done && !pdone) begin
                if (exp_done_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = exp_done_q.pop_front();
                    check("done_ack", 32'(bus_if.ack), 32'(e.ack));
                    check("done_latency", cyc - e.start, e.lat);
                end
            end
            pdone = bus_if.done;
        end
    end

    task automatic launch(input logic [23:0] d, input logic [2:0] mask, input int nb,
                          input bit full, input logic [2:0] eack, input int lat, output int k);
        done_exp_t e;
        logic [23:0] dv;
        dv = d;
        for (int i = 0; i < nb; i++) exp_byte_q.push_back(dv[23-8*i -: 8]);
        k = cyc + 1;
        if (full) begin
            exp_nb_q.push_back(nb);
            e.ack = eack; e.start = k; e.lat = lat;
            exp_done_q.push_back(e);
        end
        nack_mask = mask;
        bus_if.i2c_data = d;
        bus_if.go = 1'b1;
        @(negedge clk);
        check("start_busy", 32'(bus_if.busy), 32'd1);
        check("start_ack_clear", 32'(bus_if.ack), 32'd0);
        check("start_scl", 32'(scl), 32'd1);
        check("start_sda", 32'(sda), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus_if.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.done) fail_now("done_timeout");
    endtask

    task automatic release_go();
        bus_if.go = 1'b0;
        @(negedge clk);
        check("done_clear", 32'(bus_if.done), 32'd0);
    endtask

    initial begin
        int k, lowcnt, s0;
        bus_if.go = 1'b0;
        bus_if.i2c_data = '0;
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_ack", 32'(bus_if.ack), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // All bytes acknowledged, then go held high long after done
        launch(24'h341E00, 3'b000, 3, 1'b1, 3'b000, 116, k);
        wait_done();
        s0 = starts; lowcnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (!bus_if.done || bus_if.busy) lowcnt++;
        end
        check("hold_done_steady", lowcnt, 0);
        check("hold_no_restart", starts - s0, 0);
        release_go();
        launch(24'h341E00, 3'b000, 3, 1'b1, 3'b000, 116, k);
        wait_done();
        release_go();

        // Address NACK
        if (ABORT) launch(24'h341E00, 3'b100, 1, 1'b1, 3'b111, 44, k);
        else       launch(24'h341E00, 3'b100, 3, 1'b1, 3'b100, 116, k);
        wait_done();
        release_go();

        // Last data byte NACK
        launch(24'h341E00, 3'b001, 3, 1'b1, 3'b001, 116, k);
        wait_done();
        release_go();

        // Middle byte NACK with alternating pattern
        if (ABORT) launch(24'hA55AC3, 3'b010, 2, 1'b1, 3'b011, 80, k);
        else       launch(24'hA55AC3, 3'b010, 3, 1'b1, 3'b010, 116, k);
        wait_done();
        release_go();

        // Reset during slot 10 (slot 10 q0 spans cycle k+44)
        launch(24'h341E00, ABORT ? 3'b000 : 3'b100, 1, 1'b0, 3'b000, 0, k);
        while (cyc < k + 44) @(negedge clk);
        reset = 1'b1;
        bus_if.go = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        slave_drive = 1'b0;
        check("abort_scl", 32'(scl), 32'd1);
        check("abort_sda", 32'(sda), 32'd1);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_done", 32'(bus_if.done), 32'd0);
        check("abort_ack", 32'(bus_if.ack), 32'd0);
        launch(24'h341E00, 3'b000, 3, 1'b1, 3'b000, 116, k);
        wait_done();
        release_go();

        // Input word changes mid-transfer are ignored
        launch(24'h341E00, 3'b000, 3, 1'b1, 3'b000, 116, k);
        while (cyc < k + 25) @(negedge clk);
        bus_if.i2c_data = 24'hFFFFFF;
        wait_done();
        release_go();

        repeat (10) @(negedge clk);
        check("leftover_expect", exp_byte_q.size() + exp_nb_q.size() + exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2c_write_engine.md
# i2c_write_engine

Bit-level I2C master write engine for the WM8731 codec configuration path. It accepts one 24-bit word `{slave_addr, sub_addr, data}` from the register-sequencing stage through a go/done handshake. It serialises the word as a three-byte I2C write (START, 3×(8 bits + ACK slot), STOP) on `I2C_SCLK`/`I2C_SDAT` and reports per-byte acknowledge status. It sits directly downstream of the codec configuration sequencer and directly drives the codec's control pins.

## Interface

Parameters:
- `NBYTES`, default 3, number of bytes per transfer (fixed at 3 in this design; width of `i2c_data` = 8·NBYTES).

Ports:
- `clk_i2c` in 1: engine clock (10 kHz); four clocks per I2C bit.
- `reset` in 1: synchronous, active-high reset.
- `i2c_data` in 24: `[23:16]` slave address + R/W, `[15:8]` sub-address, `[7:0]` data; sent MSB first.
- `go` in 1: transfer request, level; sequencer holds it high until `done`.
- `done` out 1: transfer complete; high from end of STOP until `go` is sampled low.
- `busy` out 1: high from START through STOP.
- `ack` out 3: per-byte NACK flags; `ack[2]` = byte 0 (address), `ack[1]` = byte 1, `ack[0]` = byte 2; 1 = NACK or not sent.
- `I2C_SCLK` out 1: I2C clock, push-pull.
- `I2C_SDAT` inout 1: I2C data, open-drain (drives 0 or Z).

## Operation

- States: IDLE, START, BIT, STOP, DONE. A 2-bit quarter counter `q` (0..3) runs in START/BIT/STOP. A slot counter 0..26 tracks BIT slots: slot 9b+8 is the ACK slot of byte b.
- IDLE: SCLK=1, SDAT=Z. If `go`=1 and `done`=0: latch `i2c_data`, clear `ack` to 0, set busy, enter START q=0.
- START: q0,q1: SCLK=1, SDAT=0. q2,q3: SCLK=0, SDAT=0. Then BIT slot 0.
- BIT data slot: SDAT = latched bit (1→Z, 0→drive 0) from q0. SCLK is 0 at q0, 1 at q1–q2, 0 at q3.
- BIT ACK slot: SDAT=Z, same SCLK pattern. SDAT is sampled at q2; a sampled 1 sets the byte's `ack` flag.
- After slot 26 q3: STOP. q0: SCLK=0, SDAT=0. q1: SCLK=1, SDAT=0. q2,q3: SCLK=1, SDAT=Z. Then DONE.
- DONE: `done`=1, busy=0, bus idle. When `go`=0 is sampled, `done` clears and the engine returns to IDLE. A `go` held high never starts a second transfer.
- `i2c_data` changes and `go` deassertion during START/BIT/STOP are ignored.
- Reset (any state): next cycle SCLK=1, SDAT=Z, `done`=0, `busy`=0, `ack`=0, state IDLE. Aborting mid-transfer does not generate a STOP.

## Timing

- `go` is sampled high at edge k. START q0 outputs are valid after edge k; `busy` rises after edge k.
- Full transfer: 4 (START) + 27×4 (BIT) + 4 (STOP) = 116 cycles. `done` rises after edge k+116; `busy` falls on the same edge.
- `ack` bits update after the q2 edge of their ACK slot and hold until the next START.
- `done` falls one cycle after `go` is sampled low. The earliest next START is after the following edge on which `go`=1.
- SCLK high time is 2 cycles and low time 2 cycles, giving 2.5 kHz SCL at a 10 kHz clock. SDAT changes only while SCLK=0, except for the START/STOP edges.

## Configuration

- `I2C_NACK_ABORT_EN` defined:
  - A NACK in the ACK slot of byte b skips the remaining slots; STOP begins at the next cycle after that slot's q3.
  - `ack` flags of all unsent bytes are set to 1.
  - Transfer length = 4 + 36·(b+1) + 4 cycles.
- Not defined: a NACK only sets its flag, and all 27 slots are always sent (116 cycles).

## Test plan

- `i2c_data`=24'h34_1E_00, slave ACKs every byte. Required:
  - bus carries START, 0x34, 0x1E, 0x00 MSB first, then STOP;
  - `done` rises exactly 116 cycles after `go`;
  - `ack`=3'b000.
- Address NACK (SDAT=Z at slot 8):
  - with `I2C_NACK_ABORT_EN`: STOP directly after slot 8, `done` at 44 cycles, `ack`=3'b111;
  - without: `done` at 116 cycles, `ack`=3'b100.
- Data-byte NACK only (slot 26) → `ack`=3'b001 in both builds; `done` at 116 cycles.
- `go` held high for 300 cycles after `done` → exactly one transfer, `done` stays 1. `go` low for 1 cycle then high → `done` clears, a second START follows.
- `reset` pulsed during slot 10 → next cycle SCLK=1, SDAT=Z, `busy`=0, `done`=0, `ack`=0. The next `go` restarts from START with the full 116-cycle timing.
- `i2c_data` changed from 24'h34_1E_00 to 24'hFF_FF_FF at slot 5 → the bus still carries 0x34, 0x1E, 0x00.
